fetch_ctrl: RTL

Fetch sequencer for the RV32I 5-stage pipeline. It owns the instruction-memory request/acknowledge handshake and computes the value loaded into the program-counter register. It arbitrates between sequential fetch, ID-stage branch/JAL redirects and EX-stage JALR redirects, and applies hazard-unit stalls. It feeds the IF/ID register and delivers a valid-qualified instruction, including a one-entry hold buffer for responses that arrive during a stall.

---
 rtl/fetch_ctrl_pkg.sv | 24 ++
 rtl/fetch_hold_buf.sv | 37 +++
 rtl/fetch_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared definitions for the IF-stage fetch sequencer:
//   fetch_state_t : sequencer states
//   redir_src_t   : which source feeds next_pc (exported for trace/debug)
//   INST_NOP      : instruction presented to IF/ID while nothing is live
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      RST_IDLE = 2'd0,
      FETCH    = 2'd1,
      KILL     = 2'd2,
      STALLED  = 2'd3
   } fetch_state_t;

   typedef enum logic [1:0] {
      SRC_SEQ  = 2'd0,
      SRC_BR   = 2'd1,
      SRC_JALR = 2'd2,
      SRC_PEND = 2'd3
   } redir_src_t;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf
// One-entry holding register for an instruction response that arrives while
// the pipeline is stalled.
// Ports:
//   clk     : clock
//   reset   : asynchronous, active-low reset
//   i_load  : capture i_data
//   i_clear : return the buffer to zero (takes priority over i_load)
//   i_data  : instruction to capture
//   o_data  : buffered instruction
module fetch_hold_buf #(
   parameter int size = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_load,
   input  logic            i_clear,
   input  logic [size-1:0] i_data,
   output logic [size-1:0] o_data
);

   logic [size-1:0] r_data;

   // Clear wins so a redirect in the same cycle can never leave stale data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data <= '0;
      end else if (i_clear) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_data;
      end
   end

   assign o_data = r_data;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Fetch sequencer: owns the imem request/ack handshake, chooses the PC load
// value (sequential, ID branch/JAL, EX JALR, or a redirect remembered while a
// request was outstanding), applies stalls and delivers a valid-qualified
// instruction to IF/ID.
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   pc_cur                    : current PC (word addressed, step is +1)
//   stall                     : hazard-unit stall
//   br_req/br_target          : taken branch/JAL from ID
//   jalr_req/jalr_target      : JALR from EX (older, wins over br_req)
//   imem_req/imem_ack/rdata   : instruction memory handshake
//   pc_we/next_pc             : combinational PC register load
//   if_valid/if_instr         : registered instruction to IF/ID
//   flush_id                  : combinational kill of the ID instruction
module fetch_ctrl #(
   parameter int              size     = 32,
   parameter logic [size-1:0] INST_NOP = fetch_ctrl_pkg::INST_NOP
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [size-1:0] pc_cur,
   input  logic            stall,
   input  logic            br_req,
   input  logic [size-1:0] br_target,
   input  logic            jalr_req,
   input  logic [size-1:0] jalr_target,
   output logic            imem_req,
   input  logic            imem_ack,
   input  logic [size-1:0] imem_rdata,
   output logic            pc_we,
   output logic [size-1:0] next_pc,
   output logic            if_valid,
   output logic [size-1:0] if_instr,
   output logic            flush_id
);

   import fetch_ctrl_pkg::*;

   fetch_state_t    r_state;
   logic            r_if_valid;
   logic [size-1:0] r_if_instr;
   logic [size-1:0] r_pend_tgt;

   logic            w_redir;
   logic [size-1:0] w_tgt;
   redir_src_t      w_redir_src;
   redir_src_t      w_src;
   logic            w_pc_we;
   logic            w_imem_req;
   logic [size-1:0] w_next_pc;
   logic            w_hold_load;
   logic            w_hold_clear;
   logic [size-1:0] w_hold_data;

   // JALR is the older instruction, so it squashes a same-cycle branch.
   assign w_redir     = jalr_req | br_req;
   assign w_tgt       = jalr_req ? jalr_target : br_target;
   assign w_redir_src = jalr_req ? SRC_JALR : SRC_BR;

   // Request and PC-load decisions; a redirect always beats a stall.
   always_comb begin
      w_imem_req = 1'b0;
      w_pc_we    = 1'b0;
      w_src      = SRC_SEQ;
      case (r_state)
         FETCH: begin
            w_imem_req = ~stall;
            if (imem_ack) begin
               w_pc_we = 1'b1;
               w_src   = w_redir ? w_redir_src : SRC_SEQ;
            end
         end
         KILL: begin
            w_imem_req = 1'b1;
            if (imem_ack) begin
               w_pc_we = 1'b1;
               w_src   = w_redir ? w_redir_src : SRC_PEND;
            end
         end
         STALLED: begin
            if (w_redir) begin
               w_pc_we = 1'b1;
               w_src   = w_redir_src;
            end
         end
         default: ;
      endcase
   end

   // next_pc reads zero whenever the PC is not being loaded.
   always_comb begin
      w_next_pc = '0;
      if (w_pc_we) begin
         case (w_src)
            SRC_SEQ:  w_next_pc = pc_cur + {{(size-1){1'b0}}, 1'b1};
            SRC_BR:   w_next_pc = br_target;
            SRC_JALR: w_next_pc = jalr_target;
            SRC_PEND: w_next_pc = r_pend_tgt;
            default:  w_next_pc = '0;
         endcase
      end
   end

   assign w_hold_load  = (r_state == FETCH) & imem_ack & ~w_redir & stall;
   assign w_hold_clear = (r_state == STALLED) & (w_redir | ~stall);

   fetch_hold_buf #(.size(size)) u_hold_buf (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_hold_load),
      .i_clear (w_hold_clear),
      .i_data  (imem_rdata),
      .o_data  (w_hold_data)
   );

   // Main sequencer. if_instr is forced to NOP whenever if_valid drops so
   // IF/ID never sees a stale instruction word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= RST_IDLE;
         r_if_valid <= 1'b0;
         r_if_instr <= INST_NOP;
         r_pend_tgt <= '0;
      end else begin
         case (r_state)
            RST_IDLE: begin
               r_state <= FETCH;
            end
            FETCH: begin
               if (imem_ack) begin
                  if (w_redir) begin
                     r_if_valid <= 1'b0;
                     r_if_instr <= INST_NOP;
                  end else if (!stall) begin
                     r_if_valid <= 1'b1;
                     r_if_instr <= imem_rdata;
                  end else begin
                     r_state <= STALLED;
                  end
               end else if (w_redir) begin
                  // The in-flight response belongs to the wrong path; wait it out.
                  r_pend_tgt <= w_tgt;
                  r_state    <= KILL;
                  r_if_valid <= 1'b0;
                  r_if_instr <= INST_NOP;
               end else if (!stall) begin
                  r_if_valid <= 1'b0;
                  r_if_instr <= INST_NOP;
               end
            end
            KILL: begin
               r_if_valid <= 1'b0;
               r_if_instr <= INST_NOP;
               if (w_redir) begin
                  r_pend_tgt <= w_tgt;
               end
               if (imem_ack) begin
                  r_state <= FETCH;
               end
            end
            STALLED: begin
               if (w_redir) begin
                  r_if_valid <= 1'b0;
                  r_if_instr <= INST_NOP;
                  r_state    <= FETCH;
               end else if (!stall) begin
                  r_if_valid <= 1'b1;
                  r_if_instr <= w_hold_data;
                  r_state    <= FETCH;
               end
            end
            default: begin
               r_state <= RST_IDLE;
            end
         endcase
      end
   end

   assign imem_req = w_imem_req;
   assign pc_we    = w_pc_we;
   assign next_pc  = w_next_pc;
   assign if_valid = r_if_valid;
   assign if_instr = r_if_instr;
   assign flush_id = jalr_req & (r_state != RST_IDLE);

endmodule
